// File: rtl/spi_txn_sequencer.sv
// Command/response sequencer in front of the free-running SPI master.
// Queues host commands, presents one at a time on m_*, and returns one response per command.
module spi_txn_sequencer #(
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned RSP_DEPTH = 8,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_err,
  output logic       rsp_wr,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       m_wr,
  output logic [7:0] m_addr,
  output logic [7:0] m_din,
  input  logic       m_done,
  input  logic       m_err,
  input  logic [7:0] m_dout,
  output logic       busy,
  output logic [3:0] cmd_count,
  output logic [3:0] rsp_count
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam logic [CAW:0] CMD_FULL = CMD_DEPTH[CAW:0];
  localparam logic [RAW:0] RSP_FULL = RSP_DEPTH[RAW:0];

  typedef enum logic {DUMMY, ISSUED} state_t;

  logic [16:0]  r_cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] r_cmd_rd, r_cmd_wr;
  logic [CAW:0] r_cmd_cnt;
  logic [17:0]  r_rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] r_rsp_rd, r_rsp_wr;
  logic [RAW:0] r_rsp_cnt;

  state_t     r_state;
  logic       r_m_wr;
  logic [7:0] r_m_addr;
  logic [7:0] r_m_din;
  logic       r_busy;

  logic           w_cmd_ready;
  logic           w_cmd_push;
  logic           w_rsp_valid;
  logic           w_rsp_pop;
  logic           w_cmp;
  logic           w_cmd_avail;
  logic           w_issue_ok;
  logic [CAW-1:0] w_cmd_rd_nxt;
  logic [16:0]    w_next_cmd;
  logic [7:0]     w_rdata;
  logic [CAW:0]   w_cmd_cnt_nxt;
  logic [RAW:0]   w_rsp_cnt_nxt;

  assign w_cmd_ready  = (r_cmd_cnt != CMD_FULL);
  assign w_cmd_push   = cmd_valid && w_cmd_ready;
  assign w_rsp_valid  = (r_rsp_cnt != '0);
  assign w_rsp_pop    = w_rsp_valid && rsp_ready;
  assign w_cmp        = m_done && (r_state == ISSUED);
  assign w_cmd_rd_nxt = r_cmd_rd + 1'b1;
  assign w_rdata      = (!r_m_wr && !m_err) ? m_dout : 8'h00;

  // A completing command still occupies the head, so the next one is one slot further on.
  assign w_cmd_avail = w_cmp ? (r_cmd_cnt[CAW:1] != '0) : (r_cmd_cnt != '0);
  assign w_next_cmd  = w_cmp ? r_cmd_mem[w_cmd_rd_nxt] : r_cmd_mem[r_cmd_rd];
  assign w_issue_ok  = w_cmd_avail && (w_rsp_cnt_nxt < RSP_FULL);

  always_comb begin
    w_cmd_cnt_nxt = r_cmd_cnt;
    if (w_cmd_push) w_cmd_cnt_nxt = w_cmd_cnt_nxt + 1'b1;
    if (w_cmp)      w_cmd_cnt_nxt = w_cmd_cnt_nxt - 1'b1;
    w_rsp_cnt_nxt = r_rsp_cnt;
    if (w_cmp)      w_rsp_cnt_nxt = w_rsp_cnt_nxt + 1'b1;
    if (w_rsp_pop)  w_rsp_cnt_nxt = w_rsp_cnt_nxt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_cmd_push) r_cmd_mem[r_cmd_wr] <= {cmd_wr, cmd_addr, cmd_data};
    if (!rst && w_cmp)      r_rsp_mem[r_rsp_wr] <= {m_err, r_m_wr, r_m_addr, w_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_rd  <= '0;
      r_cmd_wr  <= '0;
      r_cmd_cnt <= '0;
      r_rsp_rd  <= '0;
      r_rsp_wr  <= '0;
      r_rsp_cnt <= '0;
      r_state   <= DUMMY;
      r_m_wr    <= 1'b0;
      r_m_addr  <= IDLE_ADDR;
      r_m_din   <= '0;
      r_busy    <= 1'b0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + 1'b1;
      if (w_cmp) begin
        r_cmd_rd <= w_cmd_rd_nxt;
        r_rsp_wr <= r_rsp_wr + 1'b1;
      end
      if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + 1'b1;
      r_cmd_cnt <= w_cmd_cnt_nxt;
      r_rsp_cnt <= w_rsp_cnt_nxt;

      if (m_done) begin
        if (w_issue_ok) begin
          r_state  <= ISSUED;
          r_busy   <= 1'b1;
          r_m_wr   <= w_next_cmd[16];
          r_m_addr <= w_next_cmd[15:8];
          r_m_din  <= w_next_cmd[7:0];
        end else begin
          r_state  <= DUMMY;
          r_busy   <= 1'b0;
          r_m_wr   <= 1'b0;
          r_m_addr <= IDLE_ADDR;
          r_m_din  <= '0;
        end
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign {rsp_err, rsp_wr, rsp_addr, rsp_data} = r_rsp_mem[r_rsp_rd];
  assign m_wr      = r_m_wr;
  assign m_addr    = r_m_addr;
  assign m_din     = r_m_din;
  assign busy      = r_busy;
  assign cmd_count = 4'(r_cmd_cnt);
  assign rsp_count = 4'(r_rsp_cnt);

endmodule
